eth_descrambler_pipe: RTL

//  Parametrised self-synchronising descrambler for the 64b/66b RX path; sits between gearbox/block-sync and PCS decode.

---
 rtl/eth_pcs_pkg.sv | 47 ++++
 rtl/eth_skid_buffer.sv | 53 +++++
 rtl/eth_descrambler_pipe.sv | 123 ++++++++++++
 3 files changed

// File: rtl/eth_pcs_pkg.sv
// Shared 64b/66b PCS types, LFSR defaults and the bit-serial descrambler function
// used by eth_descrambler_pipe (optional monitor macro: ETH_DESCRAMBLER_BER_MON_EN).
package eth_pcs_pkg;

    typedef logic [1:0] sync_hdr_t;

    localparam sync_hdr_t HDR_DATA = 2'b01;
    localparam sync_hdr_t HDR_CTRL = 2'b10;

    localparam int LFSR_STATE_W = 58;
    localparam int LFSR_TAP_A   = 38;
    localparam int LFSR_TAP_B   = 57;
    localparam int MAX_W        = 64;

    typedef struct packed {
        logic [MAX_W-1:0] state;
        logic [MAX_W-1:0] data;
    } descr_res_t;

    // Operands are right-aligned in MAX_W-bit containers; bits above dw/sw are ignored.
    function automatic descr_res_t descramble_word(
        input logic [MAX_W-1:0] din,
        input logic [MAX_W-1:0] s_in,
        input int               dw,
        input int               sw,
        input logic [5:0]       tap_a,
        input logic [5:0]       tap_b
    );
        descr_res_t       res;
        logic [MAX_W-1:0] s;
        logic [MAX_W-1:0] mask;
        logic [5:0]       jj;
        s        = s_in;
        res.data = '0;
        mask     = (sw >= MAX_W) ? '1 : ((MAX_W'(1) << sw) - MAX_W'(1));
        for (int j = MAX_W - 1; j >= 0; j--) begin
            jj = 6'(j);
            if (j < dw) begin
                res.data[jj] = din[jj] ^ s[tap_a] ^ s[tap_b];
                s = ((s << 1) | MAX_W'(din[jj])) & mask;
            end
        end
        res.state = s;
        return res;
    endfunction

endpackage

// File: rtl/eth_skid_buffer.sv
// Two-entry valid/ready stage: an output register plus one skid entry, with a
// registered ready so the upstream path never sees a combinational ready.
module eth_skid_buffer #(
    parameter int WIDTH = 35
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    logic             r_out_valid;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [WIDTH-1:0] r_skid_data;
    logic             w_accept;
    logic             w_out_free;

    assign o_ready    = ~r_skid_valid;
    assign o_valid    = r_out_valid;
    assign o_data     = r_out_data;
    assign w_accept   = i_valid & ~r_skid_valid;
    assign w_out_free = ~r_out_valid | i_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_out_data   <= '0;
            r_skid_data  <= '0;
        end else if (w_out_free) begin
            // A held skid beat always goes first; ready is low while it is held.
            if (r_skid_valid) begin
                r_out_data   <= r_skid_data;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_data  <= i_data;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid_data  <= i_data;
            r_skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/eth_descrambler_pipe.sv
// Self-synchronising 64b/66b RX descrambler with header pass-through and skid buffering.
// Define ETH_DESCRAMBLER_BER_MON_EN to build the invalid-header (hi-BER) monitor.
module eth_descrambler_pipe
    import eth_pcs_pkg::*;
#(
    parameter int                 DATA_WIDTH = 32,
    parameter int                 STATE_W    = LFSR_STATE_W,
    parameter int                 TAP_A      = LFSR_TAP_A,
    parameter int                 TAP_B      = LFSR_TAP_B,
    parameter logic [STATE_W-1:0] SEED       = '1,
    parameter int                 BER_WINDOW = 1024,
    parameter int                 BER_THRESH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_bypass,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [1:0]            i_header,
    input  logic                  i_headervalid,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [1:0]            o_header,
    output logic                  o_headervalid,
    output logic                  o_hi_ber,
    output logic [7:0]            o_err_count
);

    localparam int SKID_W = DATA_WIDTH + 3;

    logic [STATE_W-1:0]    r_state;
    descr_res_t            w_res;
    logic                  w_unused;
    logic                  w_ready;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_word;
    logic [SKID_W-1:0]     w_skid_in;
    logic [SKID_W-1:0]     w_skid_out;

    assign w_res    = descramble_word(MAX_W'(i_data), MAX_W'(r_state), DATA_WIDTH, STATE_W,
                                      6'(TAP_A), 6'(TAP_B));
    assign w_unused = ^w_res;
    assign w_accept = i_valid & w_ready;
    assign o_ready  = w_ready;

    // State always follows the line bits, so bypass beats keep the descrambler in sync.
    assign w_word    = i_bypass ? i_data : w_res.data[DATA_WIDTH-1:0];
    assign w_skid_in = {i_header, i_headervalid, w_word};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= SEED;
        end else if (w_accept) begin
            r_state <= w_res.state[STATE_W-1:0];
        end
    end

    eth_skid_buffer #(
        .WIDTH (SKID_W)
    ) u_skid (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (w_ready),
        .i_data  (w_skid_in),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (w_skid_out)
    );

    assign o_header      = w_skid_out[SKID_W-1 -: 2];
    assign o_headervalid = w_skid_out[DATA_WIDTH];
    assign o_data        = w_skid_out[DATA_WIDTH-1:0];

`ifdef ETH_DESCRAMBLER_BER_MON_EN
    localparam int WIN_W = $clog2(BER_WINDOW + 1);

    logic [WIN_W-1:0] r_win_cnt;
    logic [7:0]       r_err_cnt;
    logic             r_hi_ber;
    logic [7:0]       w_err_next;
    logic             w_hdr_beat;
    logic             w_hdr_bad;
    logic             w_win_end;
    logic             w_over;

    assign w_hdr_beat = w_accept & i_headervalid;
    assign w_hdr_bad  = (i_header == 2'b00) | (i_header == 2'b11);
    assign w_err_next = (w_hdr_bad && (r_err_cnt != 8'hFF)) ? r_err_cnt + 8'd1 : r_err_cnt;
    assign w_win_end  = (r_win_cnt == WIN_W'(BER_WINDOW - 1));
    assign w_over     = (w_err_next >= 8'(BER_THRESH));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_win_cnt <= '0;
            r_err_cnt <= '0;
            r_hi_ber  <= 1'b0;
        end else if (w_hdr_beat) begin
            if (w_win_end) begin
                // Flag only drops after a whole window below threshold.
                r_win_cnt <= '0;
                r_err_cnt <= '0;
                r_hi_ber  <= w_over;
            end else begin
                r_win_cnt <= r_win_cnt + WIN_W'(1);
                r_err_cnt <= w_err_next;
                if (w_over) begin
                    r_hi_ber <= 1'b1;
                end
            end
        end
    end

    assign o_hi_ber    = r_hi_ber;
    assign o_err_count = r_err_cnt;
`else
    assign o_hi_ber    = 1'b0;
    assign o_err_count = 8'd0;
`endif

endmodule
